// File: rtl/pi_flash_window_ctrl.sv
// PI-bus cartridge mapper: latches the ALE address, tracks the burst offset, decodes
// the runtime/boot windows and sequences the SST flash CE/OE around each PI strobe.
module pi_flash_window_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FLASH_AW    = 19,
  parameter int unsigned BURST_W     = 13,
  parameter int unsigned STROBE_MAX  = 8,
  parameter logic [31:0] WIN_BASE    = 32'h1EC00000,
  parameter logic [31:0] WIN_MASK    = 32'hFFF00000,
  parameter logic [31:0] BOOT_BASE   = 32'h10000000,
  parameter logic [31:0] BOOT_MASK   = 32'hFFFE0000,
  parameter logic [31:0] ZERO_BASE   = 32'h10020000,
  parameter logic [31:0] ZERO_MASK   = 32'hFFFE0000,
  parameter logic [31:0] UNLOCK_ADDR = 32'h10400400,
  parameter logic [15:0] UNLOCK_DATA = 16'h001E
) (
  input  logic                clk,
  input  logic                cold_reset,
  input  logic [15:0]         ad_in,
  input  logic                aleh,
  input  logic                alel,
  input  logic                read,
  input  logic                write,
  output logic [15:0]         ad_out,
  output logic                ad_oe,
  output logic [FLASH_AW-1:0] flash_addr,
  output logic                flash_ce,
  output logic                flash_oe,
  output logic                read_top,
  output logic                boot_mode,
  output logic [31:0]         pi_addr,
  output logic [15:0]         pi_wdata,
  output logic                wr_strobe
);

  // state  | meaning
  // IDLE   | flash deselected, waiting for a strobe inside a flash window
  // ACTIVE | CE low, CE counter running toward STROBE_MAX
  // HOLD   | CE time budget spent, CE high until the strobe ends
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [5:0] CE_LIMIT = 6'(STROBE_MAX);

  state_t               state, state_d;
  logic [5:0]           ce_cnt, ce_cnt_d;
  logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
  logic [BURST_W-1:0]   burst;
  logic                 rs, ws, rs_next;
  logic                 rd_fall, rd_rise, wr_fall, wr_rise;
  logic                 ale_any, ale_lo, ale_hi;
  logic                 hit_run, hit_boot, hit_zero;
  logic                 wr_armed;

  assign rs      = rd_sync[SYNC_STAGES-1];
  assign ws      = wr_sync[SYNC_STAGES-1];
  assign rs_next = rd_sync[SYNC_STAGES-2];
  assign rd_fall = rs & ~rd_sync[SYNC_STAGES-2];
  assign rd_rise = ~rs & rd_sync[SYNC_STAGES-2];
  assign wr_fall = ws & ~wr_sync[SYNC_STAGES-2];
  assign wr_rise = ~ws & wr_sync[SYNC_STAGES-2];

  assign ale_any = aleh | alel;
  assign ale_lo  = alel & ~aleh;
  assign ale_hi  = alel & aleh;

  assign hit_run  = (pi_addr & WIN_MASK) == WIN_BASE;
  assign hit_boot = boot_mode && ((pi_addr & BOOT_MASK) == BOOT_BASE);
  assign hit_zero = boot_mode && ((pi_addr & ZERO_MASK) == ZERO_BASE) && !hit_boot;

  // Only the zero-fill window is ever driven back onto the AD bus.
  assign ad_out = 16'h0000;

  always_ff @(posedge clk or negedge cold_reset) begin
    if (!cold_reset) begin
      rd_sync <= '1;
      wr_sync <= '1;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], read};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], write};
    end
  end

  always_ff @(posedge clk or negedge cold_reset) begin
    if (!cold_reset) begin
      pi_addr    <= '0;
      burst      <= '0;
      flash_addr <= '0;
      pi_wdata   <= '0;
      wr_armed   <= 1'b0;
      wr_strobe  <= 1'b0;
      boot_mode  <= 1'b1;
      read_top   <= 1'b0;
    end else begin
      if (ale_lo) pi_addr[15:0] <= ad_in;
      if (ale_hi) pi_addr[31:16] <= ad_in;

      if (ale_lo)
        burst <= '0;
      else if (rd_rise || wr_rise)
        burst <= burst + BURST_W'(1);

      if (rd_fall || wr_fall)
        flash_addr <= pi_addr[FLASH_AW:1] + FLASH_AW'(burst);

      // A write that overlaps a read is treated as a read: no data capture, no pulse.
      if (wr_fall && rs) pi_wdata <= ad_in;
      if (wr_fall)
        wr_armed <= rs;
      else if (!rs)
        wr_armed <= 1'b0;
      wr_strobe <= wr_rise && wr_armed && rs;

      if (wr_strobe && (pi_addr == UNLOCK_ADDR) && (pi_wdata == UNLOCK_DATA))
        boot_mode <= 1'b0;

      read_top <= hit_run | hit_boot | hit_zero;
    end
  end

  always_comb begin
    state_d  = state;
    ce_cnt_d = ce_cnt;
    case (state)
      ST_IDLE: begin
        if ((hit_run || hit_boot) && (!rs || !ws)) begin
          state_d  = ST_ACTIVE;
          ce_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        ce_cnt_d = ce_cnt + 6'd1;
        if (rs && ws)
          state_d = ST_IDLE;
        else if (ce_cnt_d >= CE_LIMIT)
          state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (rs && ws) begin
          state_d  = ST_IDLE;
          ce_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ale_any) state_d = ST_IDLE;
    if (ale_hi) ce_cnt_d = '0;
  end

  // Outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk or negedge cold_reset) begin
    if (!cold_reset) begin
      state    <= ST_IDLE;
      ce_cnt   <= '0;
      flash_ce <= 1'b1;
      flash_oe <= 1'b1;
      ad_oe    <= 1'b0;
    end else begin
      state    <= state_d;
      ce_cnt   <= ce_cnt_d;
      flash_ce <= (state_d != ST_ACTIVE);
      flash_oe <= (state_d == ST_IDLE) || rs_next;
      ad_oe    <= !ale_any && hit_zero && !rs;
    end
  end

endmodule

// File: tb/tb_pi_flash_window_ctrl.sv
// Randomized scoreboard bench for pi_flash_window_ctrl; a second instance with a
// 2-bit burst counter covers offset wrap.
module tb_pi_flash_window_ctrl;

  localparam logic [31:0] WIN_BASE    = 32'h1EC00000;
  localparam logic [31:0] WIN_MASK    = 32'hFFF00000;
  localparam logic [31:0] BOOT_BASE   = 32'h10000000;
  localparam logic [31:0] BOOT_MASK   = 32'hFFFE0000;
  localparam logic [31:0] ZERO_BASE   = 32'h10020000;
  localparam logic [31:0] ZERO_MASK   = 32'hFFFE0000;
  localparam logic [31:0] UNLOCK_ADDR = 32'h10400400;
  localparam logic [15:0] UNLOCK_DATA = 16'h001E;
  localparam int          SMAX        = 8;

  logic        clk, cold_reset;
  logic [15:0] ad_in;
  logic        aleh, alel, read, write;

  logic [15:0] ad_out;
  logic        ad_oe, flash_ce, flash_oe, read_top, boot_mode, wr_strobe;
  logic [18:0] flash_addr;
  logic [31:0] pi_addr;
  logic [15:0] pi_wdata;

  logic [15:0] ad_out_s;
  logic        ad_oe_s, flash_ce_s, flash_oe_s, read_top_s, boot_mode_s, wr_strobe_s;
  logic [18:0] flash_addr_s;
  logic [31:0] pi_addr_s;
  logic [15:0] pi_wdata_s;

  pi_flash_window_ctrl dut (
    .clk(clk), .cold_reset(cold_reset), .ad_in(ad_in), .aleh(aleh), .alel(alel),
    .read(read), .write(write), .ad_out(ad_out), .ad_oe(ad_oe),
    .flash_addr(flash_addr), .flash_ce(flash_ce), .flash_oe(flash_oe),
    .read_top(read_top), .boot_mode(boot_mode), .pi_addr(pi_addr),
    .pi_wdata(pi_wdata), .wr_strobe(wr_strobe)
  );

  pi_flash_window_ctrl #(.BURST_W(2)) dut_small (
    .clk(clk), .cold_reset(cold_reset), .ad_in(ad_in), .aleh(aleh), .alel(alel),
    .read(read), .write(write), .ad_out(ad_out_s), .ad_oe(ad_oe_s),
    .flash_addr(flash_addr_s), .flash_ce(flash_ce_s), .flash_oe(flash_oe_s),
    .read_top(read_top_s), .boot_mode(boot_mode_s), .pi_addr(pi_addr_s),
    .pi_wdata(pi_wdata_s), .wr_strobe(wr_strobe_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_addr;
  int          m_burst;
  bit          m_boot;

  // Scoreboard queues
  logic [31:0] oe_q[$];
  logic [31:0] oe_q2[$];
  int          ce_q[$];
  int          zf_q[$];
  logic [31:0] wa_q[$];
  logic [15:0] wd_q[$];

  function automatic bit in_win(logic [31:0] a, logic [31:0] base, logic [31:0] mask);
    return (a & mask) == base;
  endfunction

  function automatic bit m_hit_flash();
    return in_win(m_addr, WIN_BASE, WIN_MASK) || (m_boot && in_win(m_addr, BOOT_BASE, BOOT_MASK));
  endfunction

  function automatic bit m_hit_zero();
    return m_boot && in_win(m_addr, ZERO_BASE, ZERO_MASK) && !in_win(m_addr, BOOT_BASE, BOOT_MASK);
  endfunction

  function automatic logic [31:0] exp_faddr(int bw);
    return ((m_addr >> 1) + 32'(m_burst % (1 << bw))) & 32'h0007FFFF;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ale_phase(input logic [31:0] a);
    aleh = 1'b1; alel = 1'b1; ad_in = a[31:16];
    cyc(2);
    aleh = 1'b0; ad_in = a[15:0];
    cyc(2);
    alel = 1'b0;
    cyc(3);
    m_addr = a;
    m_burst = 0;
    chk("read_top", read_top, 32'(m_hit_flash() || m_hit_zero()));
  endtask

  task automatic push_read(input int len);
    if (m_hit_flash()) begin
      oe_q.push_back(exp_faddr(13));
      oe_q2.push_back(exp_faddr(2));
      ce_q.push_back(len < SMAX ? len : SMAX);
    end
    if (m_hit_zero()) zf_q.push_back(len);
  endtask

  task automatic do_read(input int len);
    push_read(len);
    read = 1'b0;
    cyc(len);
    read = 1'b1;
    cyc(8);
    m_burst++;
  endtask

  task automatic do_write(input logic [15:0] d, input int len);
    if (m_hit_flash()) ce_q.push_back(len < SMAX ? len : SMAX);
    wa_q.push_back(m_addr);
    wd_q.push_back(d);
    ad_in = d;
    write = 1'b0;
    cyc(len);
    write = 1'b1;
    cyc(8);
    m_burst++;
    if (m_addr == UNLOCK_ADDR && d == UNLOCK_DATA) m_boot = 1'b0;
  endtask

  task automatic rand_txn();
    logic [31:0] a;
    int sel, n;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       a = WIN_BASE  | ($urandom & 32'h000FFFFF);
      1:       a = BOOT_BASE | ($urandom & 32'h0001FFFF);
      2:       a = ZERO_BASE | ($urandom & 32'h0001FFFF);
      default: a = 32'h05000000 | ($urandom & 32'h00FFFFFF);
    endcase
    ale_phase(a);
    n = $urandom_range(1, 3);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0)
        do_write(16'($urandom) | 16'h0100, $urandom_range(2, 6));
      else
        do_read($urandom_range(2, 12));
    end
  endtask

  // Monitor: pops expectations whenever the DUTs present a response.
  bit p_ce, p_oe, p_oe2, p_zf, p_wr;
  int ce_len, zf_len;

  initial begin
    forever begin
      @(negedge clk);
      if (!cold_reset) begin
        p_ce = 1'b1; p_oe = 1'b1; p_oe2 = 1'b1; p_zf = 1'b0; p_wr = 1'b0;
        ce_len = 0; zf_len = 0;
      end else begin
        if (!flash_ce) ce_len++;
        if (flash_ce && !p_ce) begin
          if (ce_q.size() == 0) chk("unexpected_ce_burst", 32'(ce_len), 32'd0);
          else chk("ce_low_cycles", 32'(ce_len), 32'(ce_q.pop_front()));
          ce_len = 0;
        end
        if (!flash_oe && p_oe) begin
          if (oe_q.size() == 0) chk("unexpected_oe", 32'(flash_addr), 32'hFFFFFFFF);
          else chk("flash_addr", 32'(flash_addr), oe_q.pop_front());
        end
        if (!flash_oe_s && p_oe2) begin
          if (oe_q2.size() == 0) chk("unexpected_oe_small", 32'(flash_addr_s), 32'hFFFFFFFF);
          else chk("flash_addr_wrap", 32'(flash_addr_s), oe_q2.pop_front());
        end
        if (ad_oe) begin
          zf_len++;
          chk("ad_out_zero", 32'(ad_out), 32'h0);
        end
        if (!ad_oe && p_zf) begin
          if (zf_q.size() == 0) chk("unexpected_zero_fill", 32'(zf_len), 32'd0);
          else chk("ad_oe_cycles", 32'(zf_len), 32'(zf_q.pop_front()));
          zf_len = 0;
        end
        if (wr_strobe) begin
          chk("wr_pulse_width", 32'(p_wr), 32'd0);
          if (wa_q.size() == 0) chk("unexpected_wr_strobe", pi_addr, 32'hFFFFFFFF);
          else begin
            chk("wr_addr", pi_addr, wa_q.pop_front());
            chk("wr_data", 32'(pi_wdata), 32'(wd_q.pop_front()));
          end
        end
        p_ce = flash_ce; p_oe = flash_oe; p_oe2 = flash_oe_s; p_zf = ad_oe; p_wr = wr_strobe;
      end
    end
  end

  initial begin
    int n;
    cold_reset = 1'b0;
    ad_in = '0; aleh = 1'b0; alel = 1'b0; read = 1'b1; write = 1'b1;
    m_addr = '0; m_burst = 0; m_boot = 1'b1;

    #12;
    chk("rst_ad_out", 32'(ad_out), 32'h0);
    chk("rst_ad_oe", 32'(ad_oe), 32'h0);
    chk("rst_flash_addr", 32'(flash_addr), 32'h0);
    chk("rst_flash_ce", 32'(flash_ce), 32'h1);
    chk("rst_flash_oe", 32'(flash_oe), 32'h1);
    chk("rst_read_top", 32'(read_top), 32'h0);
    chk("rst_boot_mode", 32'(boot_mode), 32'h1);
    chk("rst_pi_addr", pi_addr, 32'h0);
    chk("rst_pi_wdata", 32'(pi_wdata), 32'h0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    @(posedge clk); #1;
    cold_reset = 1'b1;
    cyc(3);

    // Sequential reads in the runtime window
    ale_phase(32'h1EC00010);
    for (int i = 0; i < 4; i++) do_read(3);
    chk("pi_addr_latched", pi_addr, 32'h1EC00010);

    // Long read: CE budget then HOLD with OE still low
    push_read(20);
    read = 1'b0;
    cyc(6);
    chk("long_rd_ce_active", 32'(flash_ce), 32'h0);
    chk("long_rd_oe_active", 32'(flash_oe), 32'h0);
    cyc(9);
    chk("long_rd_ce_hold", 32'(flash_ce), 32'h1);
    chk("long_rd_oe_hold", 32'(flash_oe), 32'h0);
    cyc(5);
    read = 1'b1;
    cyc(8);
    m_burst++;

    // Burst wrap on the 2-bit instance
    ale_phase(32'h1EC00000);
    for (int i = 0; i < 5; i++) do_read(2);

    // Boot-mode windows before unlock
    ale_phase(32'h10020000);
    do_read(4);
    ale_phase(32'h10001000);
    do_read(3);

    for (int i = 0; i < 25; i++) rand_txn();

    // Unlock
    ale_phase(UNLOCK_ADDR);
    do_write(UNLOCK_DATA, 3);
    chk("boot_mode_cleared", 32'(boot_mode), 32'h0);

    ale_phase(32'h10020000);
    do_read(4);
    ale_phase(32'h10001000);
    do_read(3);
    chk("boot_mode_sticky", 32'(boot_mode), 32'h0);

    for (int i = 0; i < 25; i++) rand_txn();

    cyc(10);
    chk("pending_oe", 32'(oe_q.size()), 32'd0);
    chk("pending_oe_small", 32'(oe_q2.size()), 32'd0);
    chk("pending_ce", 32'(ce_q.size()), 32'd0);
    chk("pending_zero_fill", 32'(zf_q.size()), 32'd0);
    chk("pending_writes", 32'(wa_q.size()), 32'd0);

    // Asynchronous reset during an active read
    ale_phase(32'h1EC00100);
    push_read(20);
    read = 1'b0;
    n = 0;
    while (flash_ce && n < 50) begin
      cyc(1);
      n++;
    end
    chk("ce_low_before_reset", 32'(flash_ce), 32'h0);
    ce_q.delete();
    #2;
    cold_reset = 1'b0;
    #1;
    chk("async_rst_flash_ce", 32'(flash_ce), 32'h1);
    chk("async_rst_flash_oe", 32'(flash_oe), 32'h1);
    chk("async_rst_boot_mode", 32'(boot_mode), 32'h1);
    chk("async_rst_pi_addr", pi_addr, 32'h0);
    chk("async_rst_flash_addr", 32'(flash_addr), 32'h0);
    read = 1'b1;
    cyc(3);
    cold_reset = 1'b1;
    cyc(3);
    chk("post_rst_flash_ce", 32'(flash_ce), 32'h1);
    chk("post_rst_read_top", 32'(read_top), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
